// File: rtl/pacman_hareket.sv
// Grid-movement controller for Pacman: turns button levels into one-cell-per-tick
// moves on a fixed maze (wall where x and y are both odd), with buffered pending turns.
module pacman_hareket #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GRID_W  = 10,
  parameter int unsigned GRID_H  = 10,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       oyun_aktif,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] pacman_x,
  output logic [9:0] pacman_y,
  output logic [1:0] yon,
  output logic       hareket,
  output logic       takildi
);

  localparam int unsigned CW = 10;
  localparam int unsigned DW = $clog2(CLK_DIV);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MOVING  = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  localparam logic [1:0] YON_UP    = 2'd0;
  localparam logic [1:0] YON_DOWN  = 2'd1;
  localparam logic [1:0] YON_LEFT  = 2'd2;
  localparam logic [1:0] YON_RIGHT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [1:0]    yon_q, yon_d;
  logic          hareket_q, hareket_d;
  logic          takildi_q, takildi_d;
  logic [1:0]    bekleyen_yon_q, bekleyen_yon_d;
  logic          bekleyen_v_q, bekleyen_v_d;
  logic [DW-1:0] div_q, div_d;

  logic          tick_c;
  logic          basili_c;
  logic [1:0]    basili_yon_c;
  logic          hamle_c;
  logic [1:0]    hamle_yon_c;
  logic          bekleyen_tuket_c;

  // Bounds are checked before any subtraction so edges never wrap around.
  function automatic logic hedef_acik(input logic [1:0] d, input logic [CW-1:0] x,
                                      input logic [CW-1:0] y);
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic          sinir_ok;
    nx       = x;
    ny       = y;
    sinir_ok = 1'b0;
    case (d)
      YON_UP: begin
        sinir_ok = (y != '0);
        if (sinir_ok) ny = y - CW'(1);
      end
      YON_DOWN: begin
        sinir_ok = (y != CW'(GRID_H - 1));
        if (sinir_ok) ny = y + CW'(1);
      end
      YON_LEFT: begin
        sinir_ok = (x != '0);
        if (sinir_ok) nx = x - CW'(1);
      end
      default: begin
        sinir_ok = (x != CW'(GRID_W - 1));
        if (sinir_ok) nx = x + CW'(1);
      end
    endcase
    return sinir_ok && !(nx[0] && ny[0]);
  endfunction

  function automatic logic [CW-1:0] hedef_x(input logic [1:0] d, input logic [CW-1:0] x);
    case (d)
      YON_LEFT:  return x - CW'(1);
      YON_RIGHT: return x + CW'(1);
      default:   return x;
    endcase
  endfunction

  function automatic logic [CW-1:0] hedef_y(input logic [1:0] d, input logic [CW-1:0] y);
    case (d)
      YON_UP:   return y - CW'(1);
      YON_DOWN: return y + CW'(1);
      default:  return y;
    endcase
  endfunction

  // Move tick divider and button priority encoding.
  always_comb begin
    tick_c = oyun_aktif && (div_q == DW'(CLK_DIV - 1));
    div_d  = div_q;
    if (oyun_aktif) begin
      div_d = tick_c ? '0 : div_q + DW'(1);
    end

    basili_c     = btn_up || btn_down || btn_left || btn_right;
    basili_yon_c = YON_RIGHT;
    if (btn_up)        basili_yon_c = YON_UP;
    else if (btn_down) basili_yon_c = YON_DOWN;
    else if (btn_left) basili_yon_c = YON_LEFT;
  end

  // Next-state and movement decision, evaluated only on a tick.
  always_comb begin
    state_d          = state_q;
    x_d              = x_q;
    y_d              = y_q;
    yon_d            = yon_q;
    hareket_d        = 1'b0;
    takildi_d        = takildi_q;
    hamle_c          = 1'b0;
    hamle_yon_c      = yon_q;
    bekleyen_tuket_c = 1'b0;

    if (tick_c) begin
      case (state_q)
        ST_IDLE: begin
          if (bekleyen_v_q) begin
            if (hedef_acik(bekleyen_yon_q, x_q, y_q)) begin
              hamle_c          = 1'b1;
              hamle_yon_c      = bekleyen_yon_q;
              bekleyen_tuket_c = 1'b1;
            end else begin
              takildi_d = 1'b1;
              state_d   = ST_STOPPED;
            end
          end
        end
        ST_MOVING, ST_STOPPED: begin
          if (bekleyen_v_q && hedef_acik(bekleyen_yon_q, x_q, y_q)) begin
            hamle_c          = 1'b1;
            hamle_yon_c      = bekleyen_yon_q;
            bekleyen_tuket_c = 1'b1;
          end else if (hedef_acik(yon_q, x_q, y_q)) begin
            hamle_c     = 1'b1;
            hamle_yon_c = yon_q;
          end else begin
            takildi_d = 1'b1;
            state_d   = ST_STOPPED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (hamle_c) begin
      x_d       = hedef_x(hamle_yon_c, x_q);
      y_d       = hedef_y(hamle_yon_c, y_q);
      yon_d     = hamle_yon_c;
      hareket_d = 1'b1;
      takildi_d = 1'b0;
      state_d   = ST_MOVING;
    end

    // A press in the tick cycle wins over consuming the old pending turn.
    bekleyen_yon_d = bekleyen_yon_q;
    bekleyen_v_d   = bekleyen_v_q && !bekleyen_tuket_c;
    if (oyun_aktif && basili_c) begin
      bekleyen_yon_d = basili_yon_c;
      bekleyen_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      x_q            <= CW'(START_X);
      y_q            <= CW'(START_Y);
      yon_q          <= YON_UP;
      hareket_q      <= 1'b0;
      takildi_q      <= 1'b0;
      bekleyen_yon_q <= YON_UP;
      bekleyen_v_q   <= 1'b0;
      div_q          <= '0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      yon_q          <= yon_d;
      hareket_q      <= hareket_d;
      takildi_q      <= takildi_d;
      bekleyen_yon_q <= bekleyen_yon_d;
      bekleyen_v_q   <= bekleyen_v_d;
      div_q          <= div_d;
    end
  end

  assign pacman_x = x_q;
  assign pacman_y = y_q;
  assign yon      = yon_q;
  assign hareket  = hareket_q;
  assign takildi  = takildi_q;

endmodule
